// File: rtl/timer_pkg.sv
// Shared state encodings and digit limits for the BCD down timer.
package timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  MAX_MOD6  = 4'd5;
  localparam logic [3:0]  MAX_MOD10 = 4'd9;
endpackage

// File: rtl/bcd_dn_digit.sv
// One BCD down-counting digit: clamped load, wraps 0 -> MAX on decrement.
module bcd_dn_digit
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = MAX_MOD10
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               dec,
  output logic [DIGIT_W-1:0] q,
  output logic               is_zero
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      q <= '0;
    else if (load)
      q <= (ld_val > MAX) ? MAX : ld_val;
    else if (dec)
      q <= (q == '0) ? MAX : q - 4'd1;
  end

  assign is_zero = (q == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD cook timer: borrow-chained digits plus run/pause/done control.
// state    | meaning
// ST_IDLE  | loaded or reset, waiting for start
// ST_RUN   | counting down on tick
// ST_PAUSE | stopped mid-count, resumes on start
// ST_DONE  | reached zero while running, waits for load
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = NUM_DIGITS'(2)
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          loadn,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
  input  logic                          tick,
  input  logic                          start,
  input  logic                          stop,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic                          zero,
  output logic                          running,
  output logic                          done
);

  state_t                state;
  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS-1:0] dec;
  logic [NUM_DIGITS:0]   lower_zero;
  logic                  count_en;
  logic                  one_left;

  // lower_zero[i]: every digit below i is zero, so digit i takes the borrow
  assign lower_zero[0] = 1'b1;
  assign count_en      = (state == ST_RUN) && tick && loadn && !stop && !zero;
  assign zero          = lower_zero[NUM_DIGITS];
  assign one_left      = (digits == (DIGIT_W*NUM_DIGITS)'(1));

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign lower_zero[i+1] = lower_zero[i] & is_zero[i];
    assign dec[i]          = count_en & lower_zero[i];

    bcd_dn_digit #(
      .MAX(MOD6_MASK[i] ? MAX_MOD6 : MAX_MOD10)
    ) u_digit (
      .clk    (clk),
      .clrn   (clrn),
      .load   (!loadn),
      .ld_val (data[DIGIT_W*i +: DIGIT_W]),
      .dec    (dec[i]),
      .q      (digits[DIGIT_W*i +: DIGIT_W]),
      .is_zero(is_zero[i])
    );
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!loadn) begin
        state   <= ST_IDLE;
        running <= 1'b0;
      end else if (stop) begin
        if (state == ST_RUN) begin
          state   <= ST_PAUSE;
          running <= 1'b0;
        end
      end else if (start && state != ST_RUN && !zero) begin
        state   <= ST_RUN;
        running <= 1'b1;
      end else if (count_en && one_left) begin
        state   <= ST_DONE;
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed, table-driven bench for bcd_down_timer with default mm:ss digits.
module tb_bcd_down_timer;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        loadn = 1'b1;
  logic [15:0] data = 16'h0000;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] digits;
  logic        zero;
  logic        running;
  logic        done;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic        loadn;
    logic [15:0] data;
    logic        start;
    logic        stop;
    logic        tick;
    logic [15:0] e_digits;
    logic        e_running;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  bcd_down_timer dut (
    .clk    (clk),
    .clrn   (clrn),
    .loadn  (loadn),
    .data   (data),
    .tick   (tick),
    .start  (start),
    .stop   (stop),
    .digits (digits),
    .zero   (zero),
    .running(running),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic ln, logic [15:0] d, logic st, logic sp,
                              logic tk, logic [15:0] ed, logic er, logic edn);
    vec_t v;
    v.name = name; v.loadn = ln; v.data = d; v.start = st; v.stop = sp; v.tick = tk;
    v.e_digits = ed; v.e_running = er; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_all(string name, logic [15:0] ed, logic er, logic edn);
    chk({name, ".digits"},  32'(digits),  32'(ed));
    chk({name, ".running"}, 32'(running), 32'(er));
    chk({name, ".done"},    32'(done),    32'(edn));
    chk({name, ".zero"},    32'(zero),    32'(ed == 16'h0000));
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    loadn = v.loadn; data = v.data; start = v.start; stop = v.stop; tick = v.tick;
    @(posedge clk);
    #1;
    check_all(v.name, v.e_digits, v.e_running, v.e_done);
  endtask

  initial begin
    //                name        ln  data      st  sp  tk  digits    run done
    vecs.push_back(mk("ld0130",   0, 16'h0130, 0, 0, 0, 16'h0130, 0, 0));
    vecs.push_back(mk("st0130",   1, 16'h0000, 1, 0, 0, 16'h0130, 1, 0));
    vecs.push_back(mk("tk0129",   1, 16'h0000, 0, 0, 1, 16'h0129, 1, 0));
    vecs.push_back(mk("tk0128",   1, 16'h0000, 0, 0, 1, 16'h0128, 1, 0));
    vecs.push_back(mk("tk0127",   1, 16'h0000, 0, 0, 1, 16'h0127, 1, 0));
    vecs.push_back(mk("ld0100",   0, 16'h0100, 0, 0, 0, 16'h0100, 0, 0));
    vecs.push_back(mk("st0100",   1, 16'h0000, 1, 0, 0, 16'h0100, 1, 0));
    vecs.push_back(mk("tk0059",   1, 16'h0000, 0, 0, 1, 16'h0059, 1, 0));
    vecs.push_back(mk("ld1000",   0, 16'h1000, 0, 0, 0, 16'h1000, 0, 0));
    vecs.push_back(mk("st1000",   1, 16'h0000, 1, 0, 0, 16'h1000, 1, 0));
    vecs.push_back(mk("tk0959",   1, 16'h0000, 0, 0, 1, 16'h0959, 1, 0));
    vecs.push_back(mk("ld0002",   0, 16'h0002, 0, 0, 0, 16'h0002, 0, 0));
    vecs.push_back(mk("st0002",   1, 16'h0000, 1, 0, 0, 16'h0002, 1, 0));
    vecs.push_back(mk("tk0001",   1, 16'h0000, 0, 0, 1, 16'h0001, 1, 0));
    vecs.push_back(mk("tkdone",   1, 16'h0000, 0, 0, 1, 16'h0000, 0, 1));
    vecs.push_back(mk("tkpost",   1, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("stdone",   1, 16'h0000, 1, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("ldclamp",  0, 16'hFFFF, 0, 0, 0, 16'h9959, 0, 0));
    vecs.push_back(mk("ld0000",   0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk("stzero",   1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk("tkzero",   1, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk("ld0010",   0, 16'h0010, 0, 0, 0, 16'h0010, 0, 0));
    vecs.push_back(mk("st0010",   1, 16'h0000, 1, 0, 0, 16'h0010, 1, 0));
    vecs.push_back(mk("tk0009",   1, 16'h0000, 0, 0, 1, 16'h0009, 1, 0));
    vecs.push_back(mk("sptk",     1, 16'h0000, 0, 1, 1, 16'h0009, 0, 0));
    vecs.push_back(mk("stsp",     1, 16'h0000, 1, 1, 0, 16'h0009, 0, 0));
    vecs.push_back(mk("tkpause",  1, 16'h0000, 0, 0, 1, 16'h0009, 0, 0));
    vecs.push_back(mk("resume",   1, 16'h0000, 1, 0, 0, 16'h0009, 1, 0));
    vecs.push_back(mk("tk0008",   1, 16'h0000, 0, 0, 1, 16'h0008, 1, 0));
    vecs.push_back(mk("ldrun",    0, 16'h0045, 0, 0, 1, 16'h0045, 0, 0));
    vecs.push_back(mk("tkidle",   1, 16'h0000, 0, 0, 1, 16'h0045, 0, 0));
    vecs.push_back(mk("st0045",   1, 16'h0000, 1, 0, 0, 16'h0045, 1, 0));
    vecs.push_back(mk("sttkrun",  1, 16'h0000, 1, 0, 1, 16'h0044, 1, 0));
    vecs.push_back(mk("ld0001",   0, 16'h0001, 0, 0, 0, 16'h0001, 0, 0));
    vecs.push_back(mk("st0001",   1, 16'h0000, 1, 0, 0, 16'h0001, 1, 0));
    vecs.push_back(mk("tkdone2",  1, 16'h0000, 0, 0, 1, 16'h0000, 0, 1));
    vecs.push_back(mk("lddone",   0, 16'h0007, 0, 0, 0, 16'h0007, 0, 0));
    vecs.push_back(mk("st0007",   1, 16'h0000, 1, 0, 0, 16'h0007, 1, 0));

    #1;
    check_all("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;

    foreach (vecs[k]) apply(vecs[k]);

    // Asynchronous reset in the middle of a run, checked before any clock edge
    apply(mk("ld0130b", 0, 16'h0130, 0, 0, 0, 16'h0130, 0, 0));
    apply(mk("st0130b", 1, 16'h0000, 1, 0, 0, 16'h0130, 1, 0));
    apply(mk("tk0129b", 1, 16'h0000, 0, 0, 1, 16'h0129, 1, 0));
    @(negedge clk);
    loadn = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b1;
    #2 clrn = 1'b0;
    #1;
    check_all("asyncrst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rsthold", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    clrn = 1'b1; tick = 1'b0;
    apply(mk("postrst", 1, 16'h0000, 1, 0, 1, 16'h0000, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
